ps2_arrow_tx: RTL and testbench

PS2_ARROW_TX -- requirements
Module: ps2_arrow_tx

---
 rtl/ps2_arrow_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_arrow_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_arrow_tx.sv
// rtl/ps2_arrow_tx.sv - PS/2 device transmitter reporting arrow-key make/break sequences
module ps2_arrow_tx #(
    parameter int HALF_BIT = 2,
    parameter int GAP_BITS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic left,
    input  logic down,
    input  logic right,
    input  logic up,
    output logic ps2_clk,
    output logic ps2_data,
    output logic busy
);
    localparam int PW      = $clog2(HALF_BIT + 1);
    localparam int GAP_CYC = 2 * HALF_BIT * GAP_BITS;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    // Key vectors use bit 3 = left, 2 = down, 1 = right, 0 = up.
    state_t          state, state_n;
    logic [PW-1:0]   phase, phase_n;
    logic            low_half, low_half_n;
    logic [3:0]      bit_idx, bit_idx_n;
    logic [1:0]      byte_idx, byte_idx_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic [1:0]      sel, sel_n;
    logic            kind, kind_n;
    logic [3:0]      reported, reported_n;
    logic            ps2_clk_n, ps2_data_n, busy_n;

    logic [3:0]      keys;
    logic [3:0]      dirty;
    logic [1:0]      pick;
    logic [7:0]      code;
    logic [7:0]      cur_byte;
    logic            last_byte;
    logic            byte_done;

    assign keys  = {left, down, right, up};
    assign dirty = keys ^ reported;
    assign pick  = dirty[3] ? 2'd3 : dirty[2] ? 2'd2 : dirty[1] ? 2'd1 : 2'd0;

    // Scancode of the key being reported.
    always_comb begin
        case (sel)
            2'd3:    code = 8'h6B;
            2'd2:    code = 8'h72;
            2'd1:    code = 8'h74;
            default: code = 8'h75;
        endcase
    end

    // Make is E0,code; break is E0,F0,code.
    always_comb begin
        if (byte_idx == 2'd0)
            cur_byte = 8'hE0;
        else if (!kind && byte_idx == 2'd1)
            cur_byte = 8'hF0;
        else
            cur_byte = code;
    end

    assign last_byte = (byte_idx == (kind ? 2'd1 : 2'd2));

    // Frame bit i: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
        if (i == 4'd0)
            return 1'b0;
        else if (i <= 4'd8)
            return b[3'(i - 4'd1)];
        else if (i == 4'd9)
            return ~^b;
        else
            return 1'b1;
    endfunction

    // State register; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            low_half <= 1'b0;
            bit_idx  <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            sel      <= '0;
            kind     <= 1'b0;
            reported <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            low_half <= low_half_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            gap_cnt  <= gap_cnt_n;
            sel      <= sel_n;
            kind     <= kind_n;
            reported <= reported_n;
            ps2_clk  <= ps2_clk_n;
            ps2_data <= ps2_data_n;
            busy     <= busy_n;
        end
    end

    // Next-state logic: key selection, bit timing, inter-byte gap.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        low_half_n = low_half;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        gap_cnt_n  = gap_cnt;
        sel_n      = sel;
        kind_n     = kind;
        reported_n = reported;
        ps2_clk_n  = ps2_clk;
        ps2_data_n = ps2_data;
        busy_n     = busy;
        byte_done  = 1'b0;

        case (state)
            IDLE: begin
                busy_n     = 1'b0;
                ps2_clk_n  = 1'b1;
                ps2_data_n = 1'b1;
                if (|dirty) begin
                    sel_n      = pick;
                    kind_n     = keys[pick];
                    busy_n     = 1'b1;
                    byte_idx_n = 2'd0;
                    bit_idx_n  = 4'd0;
                    phase_n    = '0;
                    low_half_n = 1'b0;
                    ps2_data_n = 1'b0;
                    state_n    = FRAME;
                end
            end
            FRAME: begin
                if (phase == PW'(HALF_BIT - 1)) begin
                    phase_n = '0;
                    if (!low_half) begin
                        low_half_n = 1'b1;
                        ps2_clk_n  = 1'b0;
                    end else begin
                        low_half_n = 1'b0;
                        ps2_clk_n  = 1'b1;
                        if (bit_idx == 4'd10) begin
                            bit_idx_n  = 4'd0;
                            ps2_data_n = 1'b1;
                            if (GAP_CYC == 0) begin
                                byte_done = 1'b1;
                            end else begin
                                gap_cnt_n = '0;
                                state_n   = GAP;
                            end
                        end else begin
                            bit_idx_n  = bit_idx + 4'd1;
                            ps2_data_n = frame_bit(cur_byte, bit_idx + 4'd1);
                        end
                    end
                end else begin
                    phase_n = phase + PW'(1);
                end
            end
            GAP: begin
                ps2_clk_n  = 1'b1;
                ps2_data_n = 1'b1;
                if (gap_cnt == GW'(GAP_CYC - 1))
                    byte_done = 1'b1;
                else
                    gap_cnt_n = gap_cnt + GW'(1);
            end
            default: state_n = IDLE;
        endcase

        // End of a byte's gap: either start the next frame or retire the sequence.
        if (byte_done) begin
            phase_n    = '0;
            low_half_n = 1'b0;
            bit_idx_n  = 4'd0;
            gap_cnt_n  = '0;
            ps2_clk_n  = 1'b1;
            if (last_byte) begin
                state_n         = IDLE;
                busy_n          = 1'b0;
                byte_idx_n      = 2'd0;
                ps2_data_n      = 1'b1;
                reported_n[sel] = kind;
            end else begin
                state_n    = FRAME;
                byte_idx_n = byte_idx + 2'd1;
                ps2_data_n = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_arrow_tx.sv
// tb/tb_ps2_arrow_tx.sv - self-checking bench for ps2_arrow_tx against a waveform-level model
module tb_ps2_arrow_tx;
    localparam int H         = 2;
    localparam int G         = 1;
    localparam int FRAME_CYC = 22 * H;
    localparam int BYTE_CYC  = FRAME_CYC + 2 * H * G;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic left = 1'b0, down = 1'b0, right = 1'b0, up = 1'b0;
    logic ps2_clk, ps2_data, busy;

    ps2_arrow_tx #(.HALF_BIT(H), .GAP_BITS(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .left(left), .down(down), .right(right), .up(up),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: index 0 = left, 1 = down, 2 = right, 3 = up.
    logic [7:0] codes [4] = '{8'h6B, 8'h72, 8'h74, 8'h75};
    logic       m_rep [4];
    bit         m_active;
    int         m_t, m_len, m_key;
    logic       m_kind;
    logic [7:0] m_bytes [3];
    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         hi_log [$];
    int         low_log [$];

    // Line decoder / run-length tracking.
    logic       prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;
    logic [10:0] fb;
    int         fb_cnt = 0, hi_run = 0, low_run = 0;

    function automatic logic key_in(input int i);
        case (i)
            0: return left;
            1: return down;
            2: return right;
            default: return up;
        endcase
    endfunction

    function automatic bit model_dirty();
        for (int i = 0; i < 4; i++) if (key_in(i) != m_rep[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rep[i] = 1'b0;
        m_active = 1'b0; m_t = 0; m_len = 0;
        exp_q.delete();
        fb_cnt = 0; prev_clk = 1'b1; prev_data = 1'b1;
        prev_busy = 1'b0; hi_run = 0; low_run = 0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_active) begin
            m_t++;
            if (m_t == m_len * BYTE_CYC) begin
                m_active = 1'b0;
                m_rep[m_key] = m_kind;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_in(i) != m_rep[i]) begin
                    m_key = i; m_kind = key_in(i);
                    m_bytes[0] = 8'hE0;
                    if (m_kind) begin
                        m_bytes[1] = codes[i]; m_len = 2;
                    end else begin
                        m_bytes[1] = 8'hF0; m_bytes[2] = codes[i]; m_len = 3;
                    end
                    for (int j = 0; j < m_len; j++) exp_q.push_back(m_bytes[j]);
                    m_active = 1'b1; m_t = 0;
                    break;
                end
            end
        end
    endtask

    task automatic monitor();
        logic ec, ed, eb;
        int pos;
        logic [10:0] f;
        ec = 1'b1; ed = 1'b1; eb = 1'b0;
        if (m_active) begin
            eb  = 1'b1;
            pos = m_t % BYTE_CYC;
            if (pos < FRAME_CYC) begin
                f  = frame_of(m_bytes[m_t / BYTE_CYC]);
                ec = ((pos % (2 * H)) < H);
                ed = f[pos / (2 * H)];
            end
        end
        check("ps2_clk", ps2_clk, ec);
        check("ps2_data", ps2_data, ed);
        check("busy", busy, eb);

        if (prev_clk && !ps2_clk) begin
            check("data_stable_at_fall", ps2_data, prev_data);
            fb[fb_cnt] = ps2_data;
            fb_cnt++;
            if (fb_cnt == 11) begin
                fb_cnt = 0;
                check("start_bit", fb[0], 1'b0);
                check("stop_bit", fb[10], 1'b1);
                check("odd_parity", $countones(fb[9:1]) % 2, 1);
                rx_log.push_back(fb[8:1]);
                if (exp_q.size() == 0) check("unexpected_byte", fb[8:1], 32'hFFFF);
                else check("byte_value", fb[8:1], exp_q.pop_front());
            end
        end
        if (busy && !prev_busy) begin
            low_log.push_back(low_run); hi_run = 1;
        end else if (busy) begin
            hi_run++;
        end else if (prev_busy) begin
            check("busy_run_len", hi_run, m_len * BYTE_CYC);
            hi_log.push_back(hi_run); low_run = 1;
        end else begin
            low_run++;
        end
        prev_clk = ps2_clk; prev_data = ps2_data; prev_busy = busy;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        monitor();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active || model_dirty()) && n < 3000) begin
            step(); n++;
        end
        if (n >= 3000) check("wait_idle_timeout", 1, 0);
        repeat (3) step();
    endtask

    task automatic check_log(input string tag, input logic [7:0] e [$]);
        check({tag, "_count"}, rx_log.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            check(tag, (i < rx_log.size()) ? {24'h0, rx_log[i]} : 32'hFFFF, e[i]);
    endtask

    task automatic clear_logs();
        rx_log.delete(); hi_log.delete(); low_log.delete();
    endtask

    initial begin
        logic [7:0] e [$];
        int n;
        model_reset();
        repeat (3) step();
        check("reset_ps2_clk", ps2_clk, 1'b1);
        check("reset_ps2_data", ps2_data, 1'b1);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) step();

        // left make
        clear_logs();
        left = 1'b1;
        wait_idle();
        e = {8'hE0, 8'h6B};
        check_log("left_make", e);
        check("left_make_busy", (hi_log.size() > 0) ? hi_log[0] : -1, 96);
        repeat (20) step();
        check("left_reported_no_resend", rx_log.size(), 2);

        // left break
        clear_logs();
        left = 1'b0;
        wait_idle();
        e = {8'hE0, 8'hF0, 8'h6B};
        check_log("left_break", e);
        check("left_break_busy", (hi_log.size() > 0) ? hi_log[0] : -1, 144);

        // simultaneous down/right/up
        clear_logs();
        down = 1'b1; right = 1'b1; up = 1'b1;
        wait_idle();
        e = {8'hE0, 8'h72, 8'hE0, 8'h74, 8'hE0, 8'h75};
        check_log("multi_make", e);
        check("multi_idle_gap1", (low_log.size() > 1) ? low_log[1] : -1, 1);
        check("multi_idle_gap2", (low_log.size() > 2) ? low_log[2] : -1, 1);

        down = 1'b0; right = 1'b0; up = 1'b0;
        wait_idle();

        // right pulse during up make
        clear_logs();
        up = 1'b1;
        repeat (20) step();
        right = 1'b1;
        repeat (10) step();
        right = 1'b0;
        wait_idle();
        e = {8'hE0, 8'h75};
        check_log("pulse_ignored", e);

        up = 1'b0;
        wait_idle();

        // reset at bit 4 of second frame
        clear_logs();
        up = 1'b1;
        n = 0;
        while (!(m_active && m_t == BYTE_CYC + 4 * 2 * H) && n < 500) begin
            step(); n++;
        end
        check("reach_mid_frame", n < 500, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_ps2_clk", ps2_clk, 1'b1);
        check("midreset_ps2_data", ps2_data, 1'b1);
        check("midreset_busy", busy, 1'b0);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        wait_idle();
        e = {8'hE0, 8'hE0, 8'h75};
        check_log("after_reset", e);

        // randomized key activity
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(59) == 0) begin
                case ($urandom_range(3))
                    0: left  = ~left;
                    1: down  = ~down;
                    2: right = ~right;
                    default: up = ~up;
                endcase
            end
            step();
        end
        wait_idle();
        check("no_pending_bytes", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
